dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single DataMemory port between two requesters:
//   - the processor datapath (core port)
//   - the program/data loader or debug port (ldr port)
//  Registered-grant FSM with round-robin on contention and a bounded loader burst.
//  Drives core_stall so the PC/regfile hold while the core waits for memory.
//  Sits between the datapath's aluout/regoutB/memread/memwrite and DataMemory.
// PARAMETERS
//  AW         64  address width (bits)
//  DW         64  data width (bits)
//  MAX_BURST  4   max consecutive loader beats per grant; must be >=1
// PORTS
//  CLK          in   1    clock; all state updates on posedge
//  resetl       in   1    reset, synchronous, active-high
//  core_req     in   1    core wants a memory access this cycle (memread|memwrite)
//  core_we      in   1    1=write, 0=read
//  core_addr    in   AW   byte address
//  core_wdata   in   DW   write data
//  core_rdata   out  DW   read data
//  core_ack     out  1    beat accepted this cycle
//  core_stall   out  1    core_req & ~core_ack
//  ldr_req      in   1    loader beat request
//  ldr_we       in   1    1=write, 0=read
//  ldr_addr     in   AW   byte address
//  ldr_wdata    in   DW   write data
//  ldr_last     in   1    final beat of loader burst
//  ldr_rdata    out  DW   read data
//  ldr_ack      out  1    beat accepted this cycle
//  mem_addr     out  AW   to DataMemory Address
//  mem_wdata    out  DW   to DataMemory WriteData
//  mem_read     out  1    to DataMemory MemoryRead
//  mem_write    out  1    to DataMemory MemoryWrite
//  mem_rdata    in   DW   from DataMemory ReadData
// BEHAVIOUR
//  State (registered)
//   - state  {IDLE, CORE, LDR}
//   - last_gnt  1=CORE, 0=LDR
//   - beat_cnt  $clog2(MAX_BURST)+1 bits
//   - reset values: IDLE, last_gnt=0 (core wins first tie), beat_cnt=0
//  Outputs during reset: all outputs 0; mem_read/mem_write forced 0 whenever resetl=1.
//  Grant latency: request sampled at edge n; earliest ack/beat in cycle n+1.
//  CORE state
//   - one beat per cycle while core_req=1
//   - mem_* = core_* (mem_read=~core_we, mem_write=core_we)
//   - core_ack=1
//   - core_rdata = mem_rdata combinationally
//   - if core_req=0: no mem strobes, no ack
//  LDR state
//   - same as CORE using ldr_*, gated by ldr_req
//   - each acked beat increments beat_cnt
//  core_rdata/ldr_rdata are registered copies of the last read data when that
//  port is not granted.
//  Outside a granted beat: mem_addr/mem_wdata=0; all acks and strobes 0.
//  Next state
//   - IDLE
//     - both req: CORE if last_gnt==0, else LDR
//     - core only: CORE
//     - ldr only: LDR
//     - none: IDLE
//   - CORE
//     - last_gnt<=1
//     - ldr_req -> LDR, beat_cnt<=0
//     - else core_req -> CORE
//     - else IDLE
//   - LDR
//     - last_gnt<=0
//     - stay when ldr_req & ~ldr_last & beat_cnt<MAX_BURST-1
//     - otherwise core_req -> CORE
//     - else ldr_req & ~ldr_last -> LDR, new burst, beat_cnt<=0
//     - else IDLE
//  A burst ends on: ldr_last beat, MAX_BURST beats, or ldr_req low. Core waits at
//  most MAX_BURST+1 cycles. No idle bubble on CORE<->LDR handover.
//  Reset mid-beat: write suppressed in the reset cycle; state returns to IDLE.
//  Any in-flight request must be re-presented after reset.
// TESTING
//  - core only: core_req=1, we=1, addr=0x28, wdata=0xDEAD
//    -> ack next cycle, mem_write=1, addr 0x28; stall=1 only in the request cycle
//  - tie from reset: both req same cycle -> core beat first, then loader beat
//    next cycle (last_gnt alternates)
//  - loader burst, MAX_BURST=4: ldr_req held 6 beats, no ldr_last, core_req rises
//    at beat 2 -> ldr acks beats 1-4, core acks 1 cycle, ldr resumes beat 5
//  - ldr_last on beat 2 with core idle -> IDLE after beat 2, beat_cnt=0
//  - read path: preload 0x10=0x1234 via loader; core read 0x10
//    -> core_rdata=0x1234 on the ack cycle and held after
//  - reset pulse during a loader write beat -> mem_write=0 that cycle; IDLE; all outputs 0

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single DataMemory port between core and loader.
// Registered-grant FSM, round-robin on ties, bounded loader bursts.
module dmem_arbiter #(
    parameter int AW        = 64,
    parameter int DW        = 64,
    parameter int MAX_BURST = 4
) (
    input  logic          CLK,
    input  logic          resetl,

    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_ack,
    output logic          core_stall,

    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    input  logic          ldr_last,
    output logic [DW-1:0] ldr_rdata,
    output logic          ldr_ack,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_rdata
);

    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE,
        CORE,
        LDR
    } state_t;

    state_t        state_q, state_d;
    logic          last_gnt_q, last_gnt_d;
    logic [BW-1:0] beat_cnt_q, beat_cnt_d;
    logic [DW-1:0] core_rd_q, core_rd_d;
    logic [DW-1:0] ldr_rd_q, ldr_rd_d;

    logic core_beat;
    logic ldr_beat;
    logic core_rd_beat;
    logic ldr_rd_beat;

    // A beat only happens while granted, requested and out of reset.
    assign core_beat = !resetl && (state_q == CORE) && core_req;
    assign ldr_beat  = !resetl && (state_q == LDR) && ldr_req;

    assign core_rd_beat = core_beat && !core_we;
    assign ldr_rd_beat  = ldr_beat && !ldr_we;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (core_beat) begin
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            mem_read  = !core_we;
            mem_write = core_we;
        end else if (ldr_beat) begin
            mem_addr  = ldr_addr;
            mem_wdata = ldr_wdata;
            mem_read  = !ldr_we;
            mem_write = ldr_we;
        end
    end

    assign core_ack   = core_beat;
    assign ldr_ack    = ldr_beat;
    assign core_stall = !resetl && core_req && !core_beat;

    // Read data passes through on a read beat, otherwise the last value holds.
    assign core_rd_d = core_rd_beat ? mem_rdata : core_rd_q;
    assign ldr_rd_d  = ldr_rd_beat ? mem_rdata : ldr_rd_q;

    assign core_rdata = resetl ? '0 : core_rd_d;
    assign ldr_rdata  = resetl ? '0 : ldr_rd_d;

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (core_req && ldr_req) begin
                    state_d    = last_gnt_q ? LDR : CORE;
                    beat_cnt_d = '0;
                end else if (core_req) begin
                    state_d = CORE;
                end else if (ldr_req) begin
                    state_d    = LDR;
                    beat_cnt_d = '0;
                end
            end
            CORE: begin
                last_gnt_d = 1'b1;
                if (ldr_req) begin
                    state_d    = LDR;
                    beat_cnt_d = '0;
                end else if (core_req) begin
                    state_d = CORE;
                end else begin
                    state_d = IDLE;
                end
            end
            LDR: begin
                last_gnt_d = 1'b0;
                if (ldr_req && !ldr_last && beat_cnt_q < LAST_BEAT) begin
                    state_d    = LDR;
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end else begin
                    beat_cnt_d = '0;
                    if (core_req) begin
                        state_d = CORE;
                    end else if (ldr_req && !ldr_last) begin
                        state_d = LDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (resetl) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b0;
            beat_cnt_q <= '0;
            core_rd_q  <= '0;
            ldr_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            beat_cnt_q <= beat_cnt_d;
            core_rd_q  <= core_rd_d;
            ldr_rd_q   <= ldr_rd_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vectors for dmem_arbiter.
// Small behavioural DataMemory with combinational read.
module tb_dmem_arbiter;

    logic        CLK = 1'b0;
    logic        resetl;
    logic        core_req, core_we;
    logic [63:0] core_addr, core_wdata, core_rdata;
    logic        core_ack, core_stall;
    logic        ldr_req, ldr_we, ldr_last;
    logic [63:0] ldr_addr, ldr_wdata, ldr_rdata;
    logic        ldr_ack;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write;

    logic [63:0] dmem [32];
    int checks = 0;
    int errors = 0;
    int nb = 0;

    always #5 CLK = ~CLK;

    dmem_arbiter #(.AW(64), .DW(64), .MAX_BURST(4)) dut (
        .CLK(CLK), .resetl(resetl),
        .core_req(core_req), .core_we(core_we),
        .core_addr(core_addr), .core_wdata(core_wdata),
        .core_rdata(core_rdata), .core_ack(core_ack),
        .core_stall(core_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we),
        .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_last(ldr_last), .ldr_rdata(ldr_rdata),
        .ldr_ack(ldr_ack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem_read ? dmem[mem_addr[7:3]] : 64'h0;

    always @(posedge CLK)
        if (mem_write) dmem[mem_addr[7:3]] <= mem_wdata;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    // One cycle of loader/core traffic with expected acks.
    task automatic cyc(input string tag, input logic lr, input logic ll,
                       input logic cr, input logic ela, input logic eca);
        nxt();
        ldr_req   = lr;
        ldr_last  = ll;
        core_req  = cr;
        ldr_addr  = 64'h40 + 64'(8 * nb);
        ldr_wdata = 64'h100 + 64'(nb);
        @(negedge CLK);
        chk({tag, "_la"}, ldr_ack, ela);
        chk({tag, "_ca"}, core_ack, eca);
        chk({tag, "_st"}, core_stall, cr & ~eca);
        if (ela) begin
            chk({tag, "_la_addr"}, mem_addr, 64'h40 + 64'(8 * nb));
            nb++;
        end
        if (eca) chk({tag, "_ca_addr"}, mem_addr, core_addr);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) dmem[i] = 64'h0;
        resetl = 1'b1;
        core_req = 1'b1; core_we = 1'b1;
        core_addr = 64'h0; core_wdata = 64'h0;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_last = 1'b0;
        ldr_addr = 64'h0; ldr_wdata = 64'h0;

        // reset holds everything quiet
        nxt();
        @(negedge CLK);
        chk("rst_mw", mem_write, 0);
        chk("rst_mr", mem_read, 0);
        chk("rst_ca", core_ack, 0);
        chk("rst_la", ldr_ack, 0);
        chk("rst_st", core_stall, 0);

        // core-only write
        nxt();
        resetl = 1'b0; ldr_req = 1'b0;
        core_req = 1'b1; core_we = 1'b1;
        core_addr = 64'h28; core_wdata = 64'hDEAD;
        @(negedge CLK);
        chk("c1_ack0", core_ack, 0);
        chk("c1_st0", core_stall, 1);
        chk("c1_mw0", mem_write, 0);
        nxt();
        @(negedge CLK);
        chk("c1_ack1", core_ack, 1);
        chk("c1_st1", core_stall, 0);
        chk("c1_mw1", mem_write, 1);
        chk("c1_mr1", mem_read, 0);
        chk("c1_addr", mem_addr, 64'h28);
        chk("c1_wd", mem_wdata, 64'hDEAD);
        nxt();
        core_req = 1'b0;
        @(negedge CLK);
        chk("c1_ack2", core_ack, 0);
        chk("c1_mw2", mem_write, 0);
        chk("c1_addr2", mem_addr, 0);

        // tie from reset: core first, then loader writes 0x10
        nxt();
        resetl = 1'b1;
        nxt();
        resetl = 1'b0;
        core_req = 1'b1; core_we = 1'b0; core_addr = 64'h28;
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_last = 1'b1;
        ldr_addr = 64'h10; ldr_wdata = 64'h1234;
        @(negedge CLK);
        chk("t_ca0", core_ack, 0);
        chk("t_la0", ldr_ack, 0);
        nxt();
        @(negedge CLK);
        chk("t_ca1", core_ack, 1);
        chk("t_la1", ldr_ack, 0);
        chk("t_mr1", mem_read, 1);
        chk("t_rd1", core_rdata, 64'hDEAD);
        nxt();
        core_req = 1'b0;
        @(negedge CLK);
        chk("t_ca2", core_ack, 0);
        chk("t_la2", ldr_ack, 1);
        chk("t_mw2", mem_write, 1);
        chk("t_addr2", mem_addr, 64'h10);
        chk("t_rd2", core_rdata, 64'hDEAD);
        nxt();
        ldr_req = 1'b0; ldr_last = 1'b0;
        @(negedge CLK);
        chk("t_la3", ldr_ack, 0);

        // core read of preloaded word
        nxt();
        core_req = 1'b1; core_we = 1'b0; core_addr = 64'h10;
        @(negedge CLK);
        chk("r_st0", core_stall, 1);
        nxt();
        @(negedge CLK);
        chk("r_ca1", core_ack, 1);
        chk("r_rd1", core_rdata, 64'h1234);
        nxt();
        core_req = 1'b0;
        @(negedge CLK);
        chk("r_rd2", core_rdata, 64'h1234);
        nxt();
        @(negedge CLK);
        chk("r_rd3", core_rdata, 64'h1234);

        // loader burst of 6 with core contention at beat 2
        nb = 0; ldr_we = 1'b1; core_addr = 64'h28; core_we = 1'b0;
        cyc("b0", 1, 0, 0, 0, 0);
        cyc("b1", 1, 0, 0, 1, 0);
        cyc("b2", 1, 0, 1, 1, 0);
        cyc("b3", 1, 0, 1, 1, 0);
        cyc("b4", 1, 0, 1, 1, 0);
        cyc("b5", 1, 0, 1, 0, 1);
        chk("b5_rd", core_rdata, 64'hDEAD);
        cyc("b6", 1, 0, 0, 1, 0);
        cyc("b7", 1, 0, 0, 1, 0);
        cyc("b8", 0, 0, 0, 0, 0);
        chk("b_mem5", dmem[12], 64'h104);
        chk("b_mem6", dmem[13], 64'h105);

        // ldr_last on beat 2, then a fresh full burst
        nb = 0;
        cyc("l0", 1, 0, 0, 0, 0);
        cyc("l1", 1, 0, 0, 1, 0);
        cyc("l2", 1, 1, 0, 1, 0);
        cyc("l3", 1, 0, 0, 0, 0);
        cyc("l4", 1, 0, 0, 1, 0);
        cyc("l5", 1, 0, 1, 1, 0);
        cyc("l6", 1, 0, 1, 1, 0);
        cyc("l7", 1, 0, 1, 1, 0);
        cyc("l8", 1, 0, 1, 0, 1);
        cyc("l9", 1, 0, 0, 1, 0);
        cyc("l10", 0, 0, 0, 0, 0);

        // reset during a loader write beat
        nxt();
        ldr_req = 1'b1; ldr_we = 1'b1; ldr_last = 1'b0;
        ldr_addr = 64'h80; ldr_wdata = 64'h5555;
        @(negedge CLK);
        chk("x_la0", ldr_ack, 0);
        nxt();
        @(negedge CLK);
        chk("x_la1", ldr_ack, 1);
        chk("x_mw1", mem_write, 1);
        nxt();
        resetl = 1'b1; core_req = 1'b1; core_we = 1'b0;
        ldr_addr = 64'h88; ldr_wdata = 64'h7777;
        @(negedge CLK);
        chk("x_mw2", mem_write, 0);
        chk("x_mr2", mem_read, 0);
        chk("x_la2", ldr_ack, 0);
        chk("x_ca2", core_ack, 0);
        chk("x_st2", core_stall, 0);
        chk("x_addr2", mem_addr, 0);
        chk("x_wd2", mem_wdata, 0);
        chk("x_crd2", core_rdata, 0);
        chk("x_lrd2", ldr_rdata, 0);
        nxt();
        resetl = 1'b0;
        @(negedge CLK);
        chk("x_la3", ldr_ack, 0);
        chk("x_ca3", core_ack, 0);
        chk("x_st3", core_stall, 1);
        chk("x_mem80", dmem[16], 64'h5555);
        chk("x_mem88", dmem[17], 64'h0);
        nxt();
        @(negedge CLK);
        chk("x_ca4", core_ack, 1);
        chk("x_la4", ldr_ack, 0);
        nxt();
        core_req = 1'b0; ldr_req = 1'b0;
        nxt();
        nxt();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
